// File: rtl/fp_align_shift.sv
// Pre-add alignment for the FP accumulator: swaps operands so the larger
// magnitude is "big", then right-shifts the smaller mantissa with guard/round/sticky.
module fp_align_shift #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W:0]   a_in,
  input  logic [EXP_W+MAN_W:0]   b_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       exp_out,
  output logic [MAN_W:0]         mant_big,
  output logic [MAN_W+3:0]       mant_small,
  output logic                   sign_big,
  output logic                   eff_sub
);

  localparam int MANT_W = MAN_W + 1;
  localparam int AL_W   = MANT_W + 3;

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv;
  logic in_fire;
  logic s2_load;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s1_adv;

  // ---------------- stage 1: unpack and compare ----------------
  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MANT_W-1:0] a_mant, b_mant;
  logic              a_is_big;

  assign a_sign = a_in[EXP_W+MAN_W];
  assign b_sign = b_in[EXP_W+MAN_W];
  assign a_exp  = a_in[EXP_W+MAN_W-1:MAN_W];
  assign b_exp  = b_in[EXP_W+MAN_W-1:MAN_W];

  // Zero exponent flushes to a true zero, so denormals never contribute.
  assign a_mant = (a_exp == '0) ? '0 : {1'b1, a_in[MAN_W-1:0]};
  assign b_mant = (b_exp == '0) ? '0 : {1'b1, b_in[MAN_W-1:0]};

  // On an exact tie A stays big, which also gives sign_a when both are zero.
  assign a_is_big = {a_exp, a_mant} >= {b_exp, b_mant};

  logic [EXP_W-1:0]  s1_exp_big_q,    s1_exp_big_d;
  logic [EXP_W-1:0]  s1_diff_q,       s1_diff_d;
  logic [MANT_W-1:0] s1_mant_big_q,   s1_mant_big_d;
  logic [MANT_W-1:0] s1_mant_small_q, s1_mant_small_d;
  logic              s1_sign_big_q,   s1_sign_big_d;
  logic              s1_eff_sub_q,    s1_eff_sub_d;

  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_exp_big_d    = s1_exp_big_q;
    s1_diff_d       = s1_diff_q;
    s1_mant_big_d   = s1_mant_big_q;
    s1_mant_small_d = s1_mant_small_q;
    s1_sign_big_d   = s1_sign_big_q;
    s1_eff_sub_d    = s1_eff_sub_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_eff_sub_d = a_sign ^ b_sign;
      if (a_is_big) begin
        s1_exp_big_d    = a_exp;
        s1_diff_d       = a_exp - b_exp;
        s1_mant_big_d   = a_mant;
        s1_mant_small_d = b_mant;
        s1_sign_big_d   = a_sign;
      end else begin
        s1_exp_big_d    = b_exp;
        s1_diff_d       = b_exp - a_exp;
        s1_mant_big_d   = b_mant;
        s1_mant_small_d = a_mant;
        s1_sign_big_d   = b_sign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_exp_big_q    <= '0;
      s1_diff_q       <= '0;
      s1_mant_big_q   <= '0;
      s1_mant_small_q <= '0;
      s1_sign_big_q   <= 1'b0;
      s1_eff_sub_q    <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_exp_big_q    <= s1_exp_big_d;
      s1_diff_q       <= s1_diff_d;
      s1_mant_big_q   <= s1_mant_big_d;
      s1_mant_small_q <= s1_mant_small_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_eff_sub_q    <= s1_eff_sub_d;
    end
  end

  // ---------------- stage 2: shift with sticky ----------------
  logic [AL_W-1:0] shift_in;
  logic [AL_W-1:0] shift_out;
  logic [AL_W-1:0] lost_mask;
  logic [AL_W-1:0] aligned;
  logic            far_shift;

  assign shift_in  = {s1_mant_small_q, 3'b000};
  assign shift_out = shift_in >> s1_diff_q;
  assign far_shift = s1_diff_q >= EXP_W'(AL_W);

  // Bit gi is shifted out whenever the distance exceeds gi.
  for (genvar gi = 0; gi < AL_W; gi++) begin : g_lost
    assign lost_mask[gi] = s1_diff_q > EXP_W'(gi);
  end

  always_comb begin
    aligned = shift_out | {{(AL_W-1){1'b0}}, |(shift_in & lost_mask)};
    if (far_shift) begin
      aligned = {{(AL_W-1){1'b0}}, |s1_mant_small_q};
    end
  end

  logic [EXP_W-1:0]  exp_out_q,    exp_out_d;
  logic [MANT_W-1:0] mant_big_q,   mant_big_d;
  logic [AL_W-1:0]   mant_small_q, mant_small_d;
  logic              sign_big_q,   sign_big_d;
  logic              eff_sub_q,    eff_sub_d;

  always_comb begin
    s2_valid_d   = s2_valid_q;
    exp_out_d    = exp_out_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    sign_big_d   = sign_big_q;
    eff_sub_d    = eff_sub_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      exp_out_d    = s1_exp_big_q;
      mant_big_d   = s1_mant_big_q;
      mant_small_d = aligned;
      sign_big_d   = s1_sign_big_q;
      eff_sub_d    = s1_eff_sub_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      exp_out_q    <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
      sign_big_q   <= 1'b0;
      eff_sub_q    <= 1'b0;
    end else begin
      s2_valid_q   <= s2_valid_d;
      exp_out_q    <= exp_out_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      sign_big_q   <= sign_big_d;
      eff_sub_q    <= eff_sub_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign exp_out    = exp_out_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign sign_big   = sign_big_q;
  assign eff_sub    = eff_sub_q;

endmodule

// File: tb/tb_fp_align_shift.sv
// Bench for fp_align_shift: directed vector table, backpressure and reset
// sequences, then randomized traffic against a value-level reference model.
module tb_fp_align_shift;

  typedef struct packed {
    logic [7:0]  e;
    logic [23:0] mb;
    logic [26:0] ms;
    logic        sb;
    logic        es;
  } rec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    rec_t        r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  exp_out;
  logic [23:0] mant_big;
  logic [26:0] mant_small;
  logic        sign_big;
  logic        eff_sub;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  fp_align_shift dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .mant_big(mant_big), .mant_small(mant_small),
    .sign_big(sign_big), .eff_sub(eff_sub)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: values as integers, alignment as divide/modulo by 2^diff.
  function automatic rec_t model(input logic [31:0] a, input logic [31:0] b);
    rec_t r;
    longint ea, eb, ma, mb, ka, kb, eb_big, es_sml, m_big, m_sml, d, x, p;
    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 0) ? 0 : 64'd8388608 + a[22:0];
    mb = (eb == 0) ? 0 : 64'd8388608 + b[22:0];
    ka = ea * 64'd16777216 + ma;
    kb = eb * 64'd16777216 + mb;
    if (ka >= kb) begin
      eb_big = ea; es_sml = eb; m_big = ma; m_sml = mb; r.sb = a[31];
    end else begin
      eb_big = eb; es_sml = ea; m_big = mb; m_sml = ma; r.sb = b[31];
    end
    d = eb_big - es_sml;
    x = m_sml * 8;
    if (d >= 27) begin
      r.ms = (m_sml != 0) ? 27'd1 : 27'd0;
    end else begin
      p = 64'd1 << d;
      r.ms = 27'((x / p) | (((x % p) != 0) ? 1 : 0));
    end
    r.e  = 8'(eb_big);
    r.mb = 24'(m_big);
    r.es = a[31] ^ b[31];
    return r;
  endfunction

  // One cycle: drive at negedge, settle, log handshakes that fire at the next posedge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input bit use_tab, input rec_t tab);
    rec_t act;
    rec_t req;
    @(negedge clk);
    in_valid = v; a_in = a; b_in = b; out_ready = ordy;
    #1;
    if (out_valid) begin
      act = '{exp_out, mant_big, mant_small, sign_big, eff_sub};
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        req = q[0];
        chk("result", 64'(act), 64'(req));
        if (out_ready) begin
          xfers++;
          $display("xfer %0d exp=%02h mb=%06h ms=%07h sb=%0d es=%0d", xfers,
                   exp_out, mant_big, mant_small, sign_big, eff_sub);
          void'(q.pop_front());
        end
      end
    end
    if (in_valid && in_ready) q.push_back(use_tab ? tab : model(a, b));
  endtask

  vec_t tab[$];
  rec_t z;

  initial begin
    z = '0;
    tab.push_back('{32'h3F800000, 32'h3F000000, '{8'h7F, 24'h800000, 27'h2000000, 1'b0, 1'b0}});
    tab.push_back('{32'h40000000, 32'hC0400000, '{8'h80, 24'hC00000, 27'h4000000, 1'b1, 1'b1}});
    tab.push_back('{32'h4B800000, 32'h3F800001, '{8'h97, 24'h800000, 27'h0000005, 1'b0, 1'b0}});
    tab.push_back('{32'h7F000000, 32'h3F800000, '{8'hFE, 24'h800000, 27'h0000001, 1'b0, 1'b0}});
    tab.push_back('{32'h7F000000, 32'h00400000, '{8'hFE, 24'h800000, 27'h0000000, 1'b0, 1'b0}});
    tab.push_back('{32'h80000000, 32'h00000000, '{8'h00, 24'h000000, 27'h0000000, 1'b1, 1'b1}});
    tab.push_back('{32'h3F800000, 32'hBF800000, '{8'h7F, 24'h800000, 27'h4000000, 1'b0, 1'b1}});
    tab.push_back('{32'h3F800000, 32'h3FFFFFFF, '{8'h7F, 24'hFFFFFF, 27'h4000000, 1'b0, 1'b0}});
    tab.push_back('{32'h4C000000, 32'h3F800001, '{8'h98, 24'h800000, 27'h0000003, 1'b0, 1'b0}});
    tab.push_back('{32'h4C800000, 32'h3F800000, '{8'h99, 24'h800000, 27'h0000001, 1'b0, 1'b0}});
    tab.push_back('{32'h3F800000, 32'h7F800000, '{8'hFF, 24'h800000, 27'h0000001, 1'b0, 1'b0}});

    // Reset state, with no clock edge needed.
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({exp_out, mant_big, mant_small, sign_big, eff_sub}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with exact 2-cycle latency.
    foreach (tab[i]) begin
      step(1'b1, tab[i].a, tab[i].b, 1'b1, 1'b1, tab[i].r);
      chk("accept", 64'(in_ready), 64'd1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);
      chk("lat_cycle1", 64'(out_valid), 64'd0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);
      chk("lat_cycle2", 64'(out_valid), 64'd1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);

    // Backpressure: two accepts, stall (results checked each cycle), then in-order drain.
    step(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, '{8'h7F, 24'h800000, 27'h4000000, 1'b0, 1'b0});
    chk("bp_acc1", 64'(in_ready), 64'd1);
    step(1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b1, '{8'h80, 24'h800000, 27'h4000000, 1'b0, 1'b0});
    chk("bp_acc2", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h40800000, 32'h40800000, 1'b0, 1'b1, '{8'h81, 24'h800000, 27'h4000000, 1'b0, 1'b0});
      chk("bp_full", 64'(in_ready), 64'd0);
      chk("bp_held", 64'(out_valid), 64'd1);
    end
    step(1'b1, 32'h40800000, 32'h40800000, 1'b1, 1'b1, '{8'h81, 24'h800000, 27'h4000000, 1'b0, 1'b0});
    chk("bp_acc3", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with both stages full, asserted between clock edges.
    step(1'b1, 32'h3F800000, 32'h3F000000, 1'b0, 1'b0, z);
    step(1'b1, 32'hC0000000, 32'h40400000, 1'b0, 1'b0, z);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, z);
    chk("mid_full", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_fields", 64'({exp_out, mant_big, mant_small, sign_big, eff_sub}), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h40000000, 32'hC0400000, 1'b1, 1'b1, '{8'h80, 24'hC00000, 27'h4000000, 1'b1, 1'b1});
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);
    chk("post_rst_lat1", 64'(out_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);
    chk("post_rst_lat2", 64'(out_valid), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);

    // Randomized traffic with random backpressure; a pending pair is held until taken.
    begin
      logic [31:0] ra, rb;
      logic        rv;
      logic [7:0]  e;
      rv = 1'b0; ra = '0; rb = '0;
      for (int n = 0; n < 400; n++) begin
        if (!(rv && !in_ready)) begin
          rv = ($urandom_range(0, 9) < 7);
          ra = $urandom;
          e  = ra[30:23];
          case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: begin e = e - 8'($urandom_range(0, 30)); rb = {1'($urandom), e, 23'($urandom)}; end
            2: begin e = e + 8'($urandom_range(0, 30)); rb = {1'($urandom), e, 23'($urandom)}; end
            default: rb = {~ra[31], ra[30:23], ($urandom_range(0, 1) == 0) ? ra[22:0] : 23'($urandom)};
          endcase
        end
        step(rv, ra, rb, ($urandom_range(0, 3) != 0), 1'b0, z);
      end
    end
    for (int n = 0; n < 50 && q.size() != 0; n++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, z);
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
